// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and single-port RAM command bus seen by
// mem_port_arbiter. The arbiter takes the slave view; requesters and RAM the master view.
interface mem_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ready;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        flush;

   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;
   logic        d_ready;
   logic        d_rvalid;
   logic [31:0] d_rdata;

   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;

   logic        busy;

   modport slave (
      input  if_req, if_addr, flush,
      input  d_req, d_we, d_addr, d_wdata, d_wstrb,
      input  mem_rdata,
      output if_ready, if_rvalid, if_rdata,
      output d_ready, d_rvalid, d_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output busy
   );

   modport master (
      output if_req, if_addr, flush,
      output d_req, d_we, d_addr, d_wdata, d_wstrb,
      output mem_rdata,
      input  if_ready, if_rvalid, if_rdata,
      input  d_ready, d_rvalid, d_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port RAM between an instruction fetch port and a
// load/store port: data has priority, with a starvation guard and flush-kill for fetch.
module mem_port_arbiter #(
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic {IDLE, BUSY} state_t;
   typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

   localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT - 1);
   localparam logic [3:0] STARVE_CAP = 4'(STARVE_MAX);

   state_t     state_q, state_d;
   owner_t     owner_q, owner_d;
   logic [2:0] cnt_q, cnt_d;
   logic [3:0] starve_q, starve_d;
   logic       kill_q, kill_d;
   logic       hold_q;

   logic resp;
   logic can_accept;
   logic fetch_active;
   logic grant_fetch;
   logic grant_data;
   logic resp_valid;

   // NOTE: every variable gets its default first so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      starve_d    = starve_q;
      kill_d      = kill_q;
      grant_fetch = 1'b0;
      grant_data  = 1'b0;

      resp         = (state_q == BUSY) && (cnt_q == 3'd0);
      // The cycle after reset is also blocked so every output stays low for it.
      can_accept   = !reset && !hold_q && ((state_q == IDLE) || resp);
      fetch_active = bus.if_req && !bus.flush;

      if (state_q == BUSY) begin
         if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
         if (bus.flush && (owner_q == OWN_FETCH)) kill_d = 1'b1;
         if (resp) state_d = IDLE;
      end

      if (can_accept) begin
         if (bus.d_req && fetch_active && (starve_q == STARVE_CAP)) grant_fetch = 1'b1;
         else if (bus.d_req)                                          grant_data  = 1'b1;
         else if (fetch_active)                                       grant_fetch = 1'b1;
      end

      if (grant_fetch || grant_data) begin
         state_d = BUSY;
         cnt_d   = LAT_INIT;
         owner_d = grant_fetch ? OWN_FETCH : OWN_DATA;
         kill_d  = 1'b0;
      end

      // Only data grants taken while fetch is waiting count towards starvation.
      if (grant_fetch)
         starve_d = 4'd0;
      else if (grant_data && bus.if_req && (starve_q != STARVE_CAP))
         starve_d = starve_q + 4'd1;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         owner_q  <= OWN_FETCH;
         cnt_q    <= 3'd0;
         starve_q <= 4'd0;
         kill_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
         kill_q   <= kill_d;
      end
      hold_q <= reset;
   end

   assign resp_valid = resp && !reset;

   // A flush arriving in the response cycle still discards the fetch data.
   assign bus.if_rvalid = resp_valid && (owner_q == OWN_FETCH) && !kill_q && !bus.flush;
   assign bus.d_rvalid  = resp_valid && (owner_q == OWN_DATA);
   assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : 32'd0;
   assign bus.d_rdata   = bus.d_rvalid  ? bus.mem_rdata : 32'd0;

   assign bus.if_ready  = grant_fetch;
   assign bus.d_ready   = grant_data;

   assign bus.mem_en    = grant_fetch || grant_data;
   assign bus.mem_we    = grant_data && bus.d_we;
   assign bus.mem_addr  = grant_fetch ? bus.if_addr : (grant_data ? bus.d_addr : 32'd0);
   assign bus.mem_wdata = grant_data ? bus.d_wdata : 32'd0;
   assign bus.mem_wstrb = grant_data ? bus.d_wstrb : 4'd0;

   assign bus.busy      = (state_q == BUSY) && !reset;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// scored against a timestamp-based reference model and a shadow copy of the RAM.
module tb_mem_port_arbiter;
   localparam int MEM_LAT    = 2;
   localparam int STARVE_MAX = 4;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- RAM model driven by the DUT command bus ----------------
   logic [31:0] ram     [256];
   logic [31:0] ref_mem [256];
   logic [31:0] rd_pipe [1:MEM_LAT];

   function automatic logic [31:0] ram_init(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram[i]     = ram_init(32'(i));
         ref_mem[i] = ram_init(32'(i));
      end
      for (int k = 1; k <= MEM_LAT; k++) rd_pipe[k] = 32'd0;
   end

   always @(posedge clk) begin
      if (bus.mem_en) begin
         rd_pipe[1] <= ram[bus.mem_addr[7:0]];
         if (bus.mem_we) ram[bus.mem_addr[7:0]] <= merge(ram[bus.mem_addr[7:0]], bus.mem_wdata, bus.mem_wstrb);
      end else begin
         rd_pipe[1] <= 32'h0BAD_F00D;
      end
      for (int k = 2; k <= MEM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
   end

   assign bus.mem_rdata = rd_pipe[MEM_LAT];

   // ---------------- stimulus helpers ----------------
   function automatic logic [138:0] all_outs();
      return {bus.if_ready, bus.if_rvalid, bus.if_rdata, bus.d_ready, bus.d_rvalid, bus.d_rdata,
              bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.busy};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.if_req  = 1'b0;
      bus.if_addr = 32'd0;
      bus.flush   = 1'b0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = 32'd0;
      bus.d_wdata = 32'd0;
      bus.d_wstrb = 4'd0;
   endtask

   // Leaves the bench at the start of the first cycle that may grant.
   task automatic apply_reset();
      drive_idle();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      cyc();
      cyc();
   endtask

   // ---------------- directed scenarios ----------------
   task automatic test_reset();
      drive_idle();
      reset = 1'b1;
      bus.if_req = 1'b1; bus.if_addr = 32'h44;
      bus.d_req  = 1'b1; bus.d_addr  = 32'h88;
      @(negedge clk);
      checks++; if (all_outs() !== '0) begin failures++; $display("FAIL reset_cycle0_outputs got=%h want=0", all_outs()); end
      cyc();
      @(negedge clk);
      checks++; if (all_outs() !== '0) begin failures++; $display("FAIL reset_cycle1_outputs got=%h want=0", all_outs()); end
      cyc();
      reset = 1'b0;
      @(negedge clk);
      checks++; if (all_outs() !== '0) begin failures++; $display("FAIL reset_following_outputs got=%h want=0", all_outs()); end
      cyc();
      @(negedge clk);
      checks++; if ({bus.if_ready, bus.d_ready, bus.mem_en} !== 3'b011) begin failures++; $display("FAIL reset_first_grant got=%b want=011", {bus.if_ready, bus.d_ready, bus.mem_en}); end
      cyc();
   endtask

   task automatic test_single_load();
      apply_reset();
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
      @(negedge clk);
      checks++; if ({bus.d_ready, bus.mem_en, bus.mem_we, bus.busy} !== 4'b1100) begin failures++; $display("FAIL load_t0_ctrl got=%b want=1100", {bus.d_ready, bus.mem_en, bus.mem_we, bus.busy}); end
      checks++; if (bus.mem_addr !== 32'h100) begin failures++; $display("FAIL load_t0_addr got=%h want=00000100", bus.mem_addr); end
      cyc();
      bus.d_req = 1'b0;
      @(negedge clk);
      checks++; if ({bus.busy, bus.d_ready, bus.mem_en, bus.d_rvalid} !== 4'b1000) begin failures++; $display("FAIL load_t1_ctrl got=%b want=1000", {bus.busy, bus.d_ready, bus.mem_en, bus.d_rvalid}); end
      cyc();
      @(negedge clk);
      checks++; if (bus.d_rvalid !== 1'b1) begin failures++; $display("FAIL load_t2_rvalid got=%b want=1", bus.d_rvalid); end
      checks++; if (bus.d_rdata !== ram_init(32'h00)) begin failures++; $display("FAIL load_t2_rdata got=%h want=%h", bus.d_rdata, ram_init(32'h00)); end
      cyc();
      @(negedge clk);
      checks++; if ({bus.busy, bus.d_rvalid} !== 2'b00) begin failures++; $display("FAIL load_t3_idle got=%b want=00", {bus.busy, bus.d_rvalid}); end
   endtask

   task automatic test_simultaneous();
      apply_reset();
      bus.if_req = 1'b1; bus.if_addr = 32'h0000_0014;
      bus.d_req  = 1'b1; bus.d_addr  = 32'h0000_0030;
      @(negedge clk);
      checks++; if ({bus.if_ready, bus.d_ready, bus.mem_addr} !== {2'b01, 32'h30}) begin failures++; $display("FAIL simul_t0 got=%b/%h want=01/00000030", {bus.if_ready, bus.d_ready}, bus.mem_addr); end
      cyc();
      bus.d_req = 1'b0;
      @(negedge clk);
      checks++; if ({bus.if_ready, bus.mem_en} !== 2'b00) begin failures++; $display("FAIL simul_t1_blocked got=%b want=00", {bus.if_ready, bus.mem_en}); end
      cyc();
      @(negedge clk);
      checks++; if ({bus.d_rvalid, bus.if_ready, bus.mem_we, bus.mem_addr} !== {3'b110, 32'h14}) begin failures++; $display("FAIL simul_t2 got=%b/%h want=110/00000014", {bus.d_rvalid, bus.if_ready, bus.mem_we}, bus.mem_addr); end
      cyc();
      bus.if_req = 1'b0;
      cyc();
      @(negedge clk);
      checks++; if ({bus.if_rvalid, bus.if_rdata} !== {1'b1, ram_init(32'h14)}) begin failures++; $display("FAIL simul_t4_fetch got=%b/%h want=1/%h", bus.if_rvalid, bus.if_rdata, ram_init(32'h14)); end
   endtask

   task automatic test_starvation();
      logic [1:0] want;
      apply_reset();
      bus.if_req = 1'b1; bus.if_addr = 32'h40;
      bus.d_req  = 1'b1; bus.d_addr  = 32'h80;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c % 2 != 0) want = 2'b00;
         else            want = (c / 2 == 4) ? 2'b10 : 2'b01;
         checks++; if ({bus.if_ready, bus.d_ready} !== want) begin failures++; $display("FAIL starve_cycle%0d got=%b want=%b", c, {bus.if_ready, bus.d_ready}, want); end
         cyc();
      end
      drive_idle();
   endtask

   task automatic test_flush_kill();
      apply_reset();
      bus.if_req = 1'b1; bus.if_addr = 32'h24;
      @(negedge clk);
      checks++; if (bus.if_ready !== 1'b1) begin failures++; $display("FAIL kill_t0_grant got=%b want=1", bus.if_ready); end
      cyc();
      bus.if_req = 1'b0; bus.flush = 1'b1;
      @(negedge clk);
      checks++; if ({bus.busy, bus.if_rvalid} !== 2'b10) begin failures++; $display("FAIL kill_t1 got=%b want=10", {bus.busy, bus.if_rvalid}); end
      cyc();
      bus.flush = 1'b0; bus.d_req = 1'b1; bus.d_addr = 32'h0C;
      @(negedge clk);
      checks++; if ({bus.if_rvalid, bus.d_ready, bus.mem_addr} !== {2'b01, 32'h0C}) begin failures++; $display("FAIL kill_t2 got=%b/%h want=01/0000000c", {bus.if_rvalid, bus.d_ready}, bus.mem_addr); end
      cyc();
      bus.d_req = 1'b0;
      cyc();
      bus.if_req = 1'b1; bus.if_addr = 32'h28; bus.flush = 1'b1;
      @(negedge clk);
      checks++; if ({bus.d_rvalid, bus.if_ready, bus.mem_en} !== 3'b100) begin failures++; $display("FAIL kill_flush_grant got=%b want=100", {bus.d_rvalid, bus.if_ready, bus.mem_en}); end
      cyc();
      bus.flush = 1'b0;
      @(negedge clk);
      checks++; if (bus.if_ready !== 1'b1) begin failures++; $display("FAIL kill_regrant got=%b want=1", bus.if_ready); end
      cyc();
      bus.if_req = 1'b0;
      cyc();
      @(negedge clk);
      checks++; if ({bus.if_rvalid, bus.if_rdata} !== {1'b1, ram_init(32'h28)}) begin failures++; $display("FAIL kill_next_fetch got=%b/%h want=1/%h", bus.if_rvalid, bus.if_rdata, ram_init(32'h28)); end
   endtask

   task automatic test_reset_mid();
      int  data_before;
      bit  fetch_seen;
      apply_reset();
      // Three data grants while fetch waits behind a flush build up starvation credit.
      bus.if_req = 1'b1; bus.flush = 1'b1; bus.d_req = 1'b1; bus.d_addr = 32'h50;
      cyc(); cyc(); cyc(); cyc();
      @(negedge clk);
      checks++; if (bus.d_ready !== 1'b1) begin failures++; $display("FAIL rstmid_t0_grant got=%b want=1", bus.d_ready); end
      cyc();
      drive_idle();
      reset = 1'b1;
      @(negedge clk);
      checks++; if (all_outs() !== '0) begin failures++; $display("FAIL rstmid_t1_outputs got=%h want=0", all_outs()); end
      cyc();
      reset = 1'b0;
      @(negedge clk);
      checks++; if ({bus.busy, bus.d_rvalid} !== 2'b00) begin failures++; $display("FAIL rstmid_t2 got=%b want=00", {bus.busy, bus.d_rvalid}); end
      cyc();
      @(negedge clk);
      checks++; if ({bus.busy, bus.d_rvalid} !== 2'b00) begin failures++; $display("FAIL rstmid_t3 got=%b want=00", {bus.busy, bus.d_rvalid}); end
      cyc();
      bus.if_req = 1'b1; bus.if_addr = 32'h60; bus.d_req = 1'b1; bus.d_addr = 32'h64;
      data_before = 0;
      fetch_seen  = 1'b0;
      for (int c = 0; c < 20 && !fetch_seen; c++) begin
         @(negedge clk);
         if (bus.if_ready) fetch_seen = 1'b1;
         else if (bus.d_ready) data_before++;
         cyc();
      end
      checks++; if (!fetch_seen || data_before != STARVE_MAX) begin failures++; $display("FAIL rstmid_starve_cleared got=%0d data grants (fetch_seen=%0b) want=%0d", data_before, fetch_seen, STARVE_MAX); end
      drive_idle();
   endtask

   task automatic test_store();
      logic [31:0] init_w;
      logic [31:0] want;
      apply_reset();
      init_w = ram_init(32'h20);
      want   = {init_w[31:16], 16'hCCDD};
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h20;
      bus.d_wdata = 32'hAABB_CCDD; bus.d_wstrb = 4'b0011;
      @(negedge clk);
      checks++; if ({bus.mem_en, bus.mem_we, bus.mem_wstrb, bus.mem_wdata, bus.mem_addr} !== {2'b11, 4'b0011, 32'hAABB_CCDD, 32'h20}) begin failures++; $display("FAIL store_t0_cmd got=%b%b/%b/%h/%h want=11/0011/aabbccdd/00000020", bus.mem_en, bus.mem_we, bus.mem_wstrb, bus.mem_wdata, bus.mem_addr); end
      cyc();
      bus.d_req = 1'b0;
      cyc();
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_wdata = 32'd0; bus.d_wstrb = 4'd0;
      @(negedge clk);
      checks++; if ({bus.d_rvalid, bus.d_ready, bus.mem_we} !== 3'b110) begin failures++; $display("FAIL store_t2 got=%b want=110", {bus.d_rvalid, bus.d_ready, bus.mem_we}); end
      cyc();
      bus.d_req = 1'b0;
      cyc();
      @(negedge clk);
      checks++; if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, want}) begin failures++; $display("FAIL store_readback got=%b/%h want=1/%h", bus.d_rvalid, bus.d_rdata, want); end
      ref_mem[8'h20] = want;
   endtask

   // ---------------- randomized run against the reference model ----------------
   task automatic test_random();
      bit          inflight, own_fetch, killed, is_store, blocked;
      int          due, starve, now;
      logic [31:0] exp_data;
      bit          f_pend, d_pend;
      logic [31:0] f_addr, d_addr, d_wdata;
      logic [3:0]  d_wstrb;
      bit          d_we;
      bit          resp, accept, f_eff, gf, gd;
      logic [71:0] cmd_got, cmd_want;
      logic [2:0]  st_got, st_want;
      logic [31:0] want_if_rdata, want_d_rdata;

      apply_reset();
      inflight = 0; killed = 0; blocked = 0; starve = 0; now = 0; due = 0;
      own_fetch = 0; is_store = 0; exp_data = '0;
      f_pend = 0; d_pend = 0; f_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0; d_we = 0;

      for (int c = 0; c < 600; c++) begin
         if (!f_pend && $urandom_range(0, 1) == 1) begin
            f_pend = 1; f_addr = 32'($urandom_range(0, 15)) << 2;
         end
         if (!d_pend && $urandom_range(0, 2) != 0) begin
            d_pend = 1; d_addr = 32'($urandom_range(0, 15)) << 2;
            d_we = $urandom_range(0, 1) == 1; d_wdata = $urandom; d_wstrb = 4'($urandom);
         end
         reset       = ($urandom_range(0, 49) == 0);
         bus.flush   = ($urandom_range(0, 6) == 0);
         bus.if_req  = f_pend; bus.if_addr = f_addr;
         bus.d_req   = d_pend; bus.d_addr  = d_addr;
         bus.d_we    = d_we;   bus.d_wdata = d_wdata; bus.d_wstrb = d_wstrb;
         @(negedge clk);

         resp   = inflight && (due == now);
         accept = !reset && !blocked && (!inflight || resp);
         f_eff  = f_pend && !bus.flush;
         gf = 0; gd = 0;
         if (accept) begin
            if (d_pend && f_eff && starve == STARVE_MAX) gf = 1;
            else if (d_pend)                              gd = 1;
            else if (f_eff)                               gf = 1;
         end

         cmd_want = {gf, gd, gf || gd, gd && d_we,
                     gf ? f_addr : (gd ? d_addr : 32'd0), gd ? d_wdata : 32'd0, gd ? d_wstrb : 4'd0};
         cmd_got  = {bus.if_ready, bus.d_ready, bus.mem_en, bus.mem_we,
                     bus.mem_addr, bus.mem_wdata, bus.mem_wstrb};
         checks++; if (cmd_got !== cmd_want) begin failures++; $display("FAIL rand_cmd cycle%0d got=%h want=%h", c, cmd_got, cmd_want); end

         st_want = {inflight && !reset,
                    !reset && resp && own_fetch && !killed && !bus.flush,
                    !reset && resp && !own_fetch};
         st_got  = {bus.busy, bus.if_rvalid, bus.d_rvalid};
         checks++; if (st_got !== st_want) begin failures++; $display("FAIL rand_status cycle%0d got=%b want=%b", c, st_got, st_want); end

         want_if_rdata = st_want[1] ? exp_data : 32'd0;
         checks++; if (bus.if_rdata !== want_if_rdata) begin failures++; $display("FAIL rand_if_rdata cycle%0d got=%h want=%h", c, bus.if_rdata, want_if_rdata); end

         if (!st_want[0] || !is_store) begin
            want_d_rdata = st_want[0] ? exp_data : 32'd0;
            checks++; if (bus.d_rdata !== want_d_rdata) begin failures++; $display("FAIL rand_d_rdata cycle%0d got=%h want=%h", c, bus.d_rdata, want_d_rdata); end
         end

         if (reset) begin
            inflight = 0; starve = 0; killed = 0; blocked = 1;
         end else begin
            blocked = 0;
            if (inflight && own_fetch && bus.flush) killed = 1;
            if (resp) inflight = 0;
            if (gf || gd) begin
               inflight  = 1;
               due       = now + MEM_LAT;
               own_fetch = gf;
               killed    = 0;
               is_store  = gd && d_we;
               if (gf) begin
                  exp_data = ref_mem[f_addr[7:0]];
               end else begin
                  exp_data = ref_mem[d_addr[7:0]];
                  if (d_we) ref_mem[d_addr[7:0]] = merge(ref_mem[d_addr[7:0]], d_wdata, d_wstrb);
               end
            end
            if (gf) starve = 0;
            else if (gd && f_pend && starve < STARVE_MAX) starve++;
            if (gf) f_pend = 0;
            if (gd) d_pend = 0;
         end
         now++;
         cyc();
      end
      reset = 1'b0;
      drive_idle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      drive_idle();
      #1;
      test_reset();
      test_single_load();
      test_simultaneous();
      test_starvation();
      test_flush_kill();
      test_reset_mid();
      test_store();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2: memory read latency in cycles, legal range 1..8.
REQ-002 SHALL have parameter STARVE_MAX, default 4: maximum consecutive data grants while fetch is waiting, legal range 1..15.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 if_req  in  1  fetch access request; held until accepted.
REQ-006 if_addr  in  32  fetch word address.
REQ-007 if_ready  out  1  fetch request accepted this cycle.
REQ-008 if_rvalid  out  1  one-cycle pulse; if_rdata is valid.
REQ-009 if_rdata  out  32  fetch read data.
REQ-010 flush  in  1  pipeline redirect; discards any in-flight fetch response.
REQ-011 d_req  in  1  load/store request; held until accepted.
REQ-012 d_we  in  1  1 = store, 0 = load.
REQ-013 d_addr  in  32  data byte address.
REQ-014 d_wdata  in  32  store data.
REQ-015 d_wstrb  in  4  store byte enables.
REQ-016 d_ready  out  1  data request accepted this cycle.
REQ-017 d_rvalid  out  1  one-cycle completion pulse, for both loads and stores.
REQ-018 d_rdata  out  32  load data; don't-care for stores.
REQ-019 mem_en, mem_we, mem_addr[31:0], mem_wdata[31:0], mem_wstrb[3:0]  out  single-port RAM command.
REQ-020 mem_rdata  in  32  RAM read data, valid MEM_LAT cycles after mem_en.
REQ-021 busy  out  1  an access is in flight.

Function
REQ-022 SHALL implement a two-state FSM: IDLE (no access in flight) and BUSY (access in flight; latency counter running).
REQ-023 In any cycle where the FSM can accept (IDLE, or BUSY with the counter at 0), the block SHALL grant at most one request.
- The grant SHALL assert the corresponding *_ready combinationally in that cycle.
- The grant SHALL drive mem_en=1 with the granted address, we, wdata and wstrb; mem_we=0 for fetch.
REQ-024 Priority: data wins over fetch. Exception: if starve_cnt==STARVE_MAX and both requesters are active, fetch SHALL win.
REQ-025 starve_cnt rules:
- increments (saturating) on each data grant made while if_req=1;
- clears on each fetch grant;
- otherwise holds.
REQ-026 On a grant, the FSM SHALL go to BUSY with counter=MEM_LAT-1 and latch the owner (fetch/data) and the kill flag.
REQ-027 In BUSY, the counter SHALL decrement each cycle. When the counter is 0, the block SHALL pulse the owner's *_rvalid, with *_rdata=mem_rdata, in that same cycle.
REQ-028 Throughput: a new grant is allowed in the response cycle, giving back-to-back accesses every MEM_LAT cycles. With no new grant, the FSM returns to IDLE.
REQ-029 Every granted access SHALL produce exactly one *_rvalid pulse, except a killed fetch (REQ-030) or a reset (REQ-033).
REQ-030 flush SHALL have the following effects on fetch:
- flush=1 while a fetch is in flight SHALL set kill; that fetch then completes its latency with if_rvalid suppressed.
- flush=1 in a fetch-grant cycle SHALL suppress the grant (if_ready=0).
- flush SHALL NOT affect data accesses.
REQ-031 The block SHALL keep mem_en=0 and both *_ready=0 whenever it cannot accept; mem_en SHALL never be asserted for two accesses within one latency window.
REQ-032 busy SHALL be 1 exactly while the FSM is in BUSY.

Reset
REQ-033 reset SHALL force IDLE, counter=0, starve_cnt=0, kill=0 and owner=fetch.
- All outputs SHALL be 0 in the reset cycle and the following cycle.
- Any in-flight access SHALL be abandoned with no rvalid issued.

Verification (MEM_LAT=2, STARVE_MAX=4)
REQ-034 Single load: d_req, d_addr=0x100 at T0 -> d_ready=1 and mem_en=1 at T0; d_rvalid=1 with d_rdata=RAM[0x100] at T2; busy=1 at T1.
REQ-035 Simultaneous if_req and d_req at T0 -> data granted at T0, fetch granted at T2, if_rvalid at T4.
REQ-036 Starvation: if_req and d_req held continuously -> 4 consecutive data grants, then a fetch grant on the 5th slot, then a data grant.
REQ-037 Flush kill: fetch granted at T0, flush=1 at T1 -> no if_rvalid at T2; a data request at T2 is granted at T2.
REQ-038 Reset mid-operation: load granted at T0, reset=1 at T1 -> no d_rvalid; busy=0 and starve_cnt=0 at T2.
REQ-039 Store: d_we=1, d_wstrb=4'b0011, d_wdata=0xAABBCCDD at 0x20 -> mem_we=1 and mem_wstrb=0011 at T0; d_rvalid at T2; a subsequent load of 0x20 returns the low halfword 0xCCDD.
